key_beep_seq: RTL and testbench

Multi-key buzzer controller that generalises the single-toggle key-to-beep path to `KEY_NUM` debounced keys and two modes. It sits between the per-key debounce filters and the buzzer pin. In toggle mode, any key press flips the buzzer. In sequence mode, pressing key *i* plays *i*+1 timed chirps so the user can tell keys apart by ear.

---
 rtl/key_beep_seq.sv | 172 +++++++++++++++++
 tb/tb_key_beep_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/key_beep_seq.sv
// key_beep_seq: multi-key buzzer controller, toggle or chirp-sequence mode.
// Optional one-deep press queue: define KEY_BEEP_QUEUE_EN.
module key_beep_seq #(
  parameter int KEY_NUM    = 2,
  parameter int ON_CYCLES  = 5_000_000,
  parameter int OFF_CYCLES = 5_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_filter,
  input  logic               mode,
  output logic               beep,
  output logic               busy,
  output logic [KEY_NUM-1:0] key_event,
  output logic               drop
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ?
                        ON_CYCLES : OFF_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int RW = $clog2(KEY_NUM + 1);
  localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [RW-1:0] rem_q, rem_n;
  logic [KEY_NUM-1:0] key_d0;
  logic [KEY_NUM-1:0] press;
  logic [RW-1:0] win;
  logic any, multi, found;
  logic beep_n, busy_n, drop_n;
  logic pend_hit;
  logic [RW-1:0] pend_sel;

`ifdef KEY_BEEP_QUEUE_EN
  logic pend_v_q, pend_v_n;
  logic [RW-1:0] pend_idx_q, pend_idx_n;
  assign pend_hit = pend_v_q;
  assign pend_sel = pend_idx_q;
`else
  assign pend_hit = 1'b0;
  assign pend_sel = win;
`endif

  assign press = ~key_filter & key_d0;

  // lowest-index press wins; flag when more than one arrived together
  always_comb begin
    win   = '0;
    any   = 1'b0;
    multi = 1'b0;
    found = 1'b0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (press[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found = 1'b1;
          win   = RW'(i);
        end
      end
    end
    any = found;
  end

  // next-state, counters and registered-output values
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rem_n   = rem_q;
    beep_n  = beep;
    drop_n  = multi;
    unique case (state_q)
      IDLE: begin
        if (!mode) begin
          if (any) beep_n = ~beep;
        end else if (any || pend_hit) begin
          state_n = ON;
          beep_n  = 1'b0;
          cnt_n   = ON_LD;
          rem_n   = pend_hit ? pend_sel : win;
          if (pend_hit && any) drop_n = 1'b1;
        end else begin
          beep_n = 1'b1;
        end
      end
      ON: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else if (rem_q == '0) begin
          state_n = IDLE;
          beep_n  = 1'b1;
        end else begin
          state_n = OFF;
          beep_n  = 1'b1;
          cnt_n   = OFF_LD;
        end
      end
      OFF: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else begin
          state_n = ON;
          beep_n  = 1'b0;
          cnt_n   = ON_LD;
          rem_n   = rem_q - RW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        beep_n  = 1'b1;
      end
    endcase
`ifdef KEY_BEEP_QUEUE_EN
    pend_v_n   = pend_v_q;
    pend_idx_n = pend_idx_q;
    if (state_q == IDLE) begin
      pend_v_n = 1'b0;
    end else if (any) begin
      if (!pend_v_q) begin
        pend_v_n   = 1'b1;
        pend_idx_n = win;
      end else begin
        drop_n = 1'b1;
      end
    end
`else
    if (state_q != IDLE && any) drop_n = 1'b1;
`endif
    busy_n = (state_n != IDLE);
  end

  // state and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      key_d0    <= '1;
      beep      <= 1'b1;
      busy      <= 1'b0;
      key_event <= '0;
      drop      <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rem_q     <= rem_n;
      key_d0    <= key_filter;
      beep      <= beep_n;
      busy      <= busy_n;
      key_event <= press;
      drop      <= drop_n;
    end
  end

`ifdef KEY_BEEP_QUEUE_EN
  // pending press slot
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_v_q   <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      pend_v_q   <= pend_v_n;
      pend_idx_q <= pend_idx_n;
    end
  end
`endif

endmodule

// File: tb/tb_key_beep_seq.sv
// tb_key_beep_seq: directed checks of key_beep_seq
// with KEY_NUM=3, ON_CYCLES=4, OFF_CYCLES=3.
module tb_key_beep_seq;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] key_filter = 3'b111;
  logic       mode = 1'b0;
  logic       beep, busy, drop;
  logic [2:0] key_event;

  int n_chk = 0;
  int n_pass = 0;

  key_beep_seq #(
    .KEY_NUM(3),
    .ON_CYCLES(4),
    .OFF_CYCLES(3)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_filter(key_filter),
    .mode(mode),
    .beep(beep),
    .busy(busy),
    .key_event(key_event),
    .drop(drop)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // run n cycles, release keys after the first, record traces
  task automatic run_seq(input int n,
                         output logic [31:0] bv,
                         output logic [31:0] busv,
                         output int drops,
                         output logic [2:0] ev0);
    bv = '0;
    busv = '0;
    drops = 0;
    ev0 = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      bv   = {bv[30:0], beep};
      busv = {busv[30:0], busy};
      if (drop) drops++;
      if (i == 0) begin
        ev0 = key_event;
        key_filter = 3'b111;
      end
    end
  endtask

  logic [31:0] bv, busv;
  int drops;
  logic [2:0] ev0;

  initial begin
    // reset
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("rst_beep", beep, 1);
    chk("rst_busy", busy, 0);
    chk("rst_evt", key_event, 0);
    chk("rst_drop", drop, 0);

    // toggle mode
    key_filter = 3'b110;
    tick();
    chk("tg0_beep", beep, 0);
    chk("tg0_evt", key_event, 3'b001);
    chk("tg0_busy", busy, 0);
    tick();
    chk("tg0_evt_end", key_event, 0);
    key_filter = 3'b111;
    repeat (18) tick();
    key_filter = 3'b101;
    tick();
    chk("tg1_beep", beep, 1);
    chk("tg1_evt", key_event, 3'b010);
    key_filter = 3'b111;
    tick();

    // key2 sequence
    mode = 1'b1;
    key_filter = 3'b011;
    run_seq(20, bv, busv, drops, ev0);
    chk("seq2_evt", ev0, 3'b100);
    chk("seq2_beep", bv, 32'h0E1C3);
    chk("seq2_busy", busv, 32'hFFFFC);
    chk("seq2_drop", drops, 0);

    // simultaneous key0 + key2
    key_filter = 3'b010;
    run_seq(8, bv, busv, drops, ev0);
    chk("sim_evt", ev0, 3'b101);
    chk("sim_drops", drops, 1);
    chk("sim_beep", bv, 32'h0F);
    chk("sim_busy", busv, 32'hF0);

    // key1 pressed during key0 chirp
    key_filter = 3'b110;
    tick();
    key_filter = 3'b111;
    tick();
    key_filter = 3'b101;
    tick();
    chk("bz_evt", key_event, 3'b010);
`ifdef KEY_BEEP_QUEUE_EN
    chk("bz_drop", drop, 0);
`else
    chk("bz_drop", drop, 1);
`endif
    run_seq(14, bv, busv, drops, ev0);
    chk("bz_drops_after", drops, 0);
`ifdef KEY_BEEP_QUEUE_EN
    chk("bz_beep", bv, 32'h10E1);
    chk("bz_busy", busv, 32'h2FFE);
`else
    chk("bz_beep", bv, 32'h1FFF);
    chk("bz_busy", busv, 32'h2000);
`endif

    // reset during an OFF gap
    key_filter = 3'b101;
    tick();
    key_filter = 3'b111;
    repeat (4) tick();
    chk("off_beep", beep, 1);
    chk("off_busy", busy, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_beep", beep, 1);
    chk("arst_busy", busy, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("post_busy", busy, 0);
    chk("post_beep", beep, 1);
    key_filter = 3'b110;
    run_seq(6, bv, busv, drops, ev0);
    chk("post_evt", ev0, 3'b001);
    chk("post_beep_tr", bv[5:0], 6'b000011);
    chk("post_busy_tr", busv[5:0], 6'b111100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
